// File: rtl/hex_sr_ctrl.sv
`timescale 1ns/1ps
// hex_sr_ctrl: random-access sequencer for a 6-bit recirculating shift register.
// Define HEX_SR_CTRL_FILL_EN to zero every slot after reset via an INIT sweep.
module hex_sr_ctrl #(
  parameter int LENGTH = 400,
  parameter int ADDR_W = $clog2(LENGTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [5:0]        cmd_wdata,
  output logic              rsp_valid,
  output logic [5:0]        rsp_rdata,
  output logic              rsp_err,
  output logic              sr_recirc,
  output logic [5:0]        sr_data_in,
  input  logic [5:0]        sr_data_out,
  output logic [ADDR_W-1:0] pos
);

  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(LENGTH - 1);
  localparam logic [ADDR_W:0]   LEN_X = (ADDR_W+1)'(LENGTH);

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [5:0]        wdata;
  } cmd_t;

`ifdef HEX_SR_CTRL_FILL_EN
  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_SEEK} state_t;
  localparam state_t ST_RST = ST_INIT;
`else
  typedef enum logic {ST_IDLE, ST_SEEK} state_t;
  localparam state_t ST_RST = ST_IDLE;
`endif

  state_t state;
  cmd_t   cmd_q;
  logic   pos_last;
  logic   addr_bad;
  logic   hit;

  assign pos_last  = (pos == LAST);
  assign addr_bad  = ({1'b0, cmd_addr} >= LEN_X);
  assign hit       = (state == ST_SEEK) && (pos == cmd_q.addr);
  assign cmd_ready = (state == ST_IDLE);

  // The SR samples recirc/data_in on the same edge that advances pos, so the
  // write must be presented combinationally during the hit cycle.
  always_comb begin
    sr_recirc  = 1'b1;
    sr_data_in = '0;
    if (hit && cmd_q.we) begin
      sr_recirc  = 1'b0;
      sr_data_in = cmd_q.wdata;
    end
`ifdef HEX_SR_CTRL_FILL_EN
    if (state == ST_INIT) sr_recirc = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_RST;
      pos       <= '0;
      cmd_q     <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      pos       <= pos_last ? '0 : pos + ADDR_W'(1);
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      case (state)
`ifdef HEX_SR_CTRL_FILL_EN
        // pos doubles as the sweep counter: INIT spans pos 0..LENGTH-1.
        ST_INIT: if (pos_last) state <= ST_IDLE;
`endif
        ST_IDLE: begin
          if (cmd_valid) begin
            if (addr_bad) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              cmd_q <= '{we: cmd_we, addr: cmd_addr, wdata: cmd_wdata};
              state <= ST_SEEK;
            end
          end
        end
        ST_SEEK: begin
          if (hit) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= cmd_q.we ? 6'h00 : sr_data_out;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_RST;
      endcase
    end
  end

endmodule
